// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants and the parity helper.
// The RX side imports this package as well.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int UART_DATA_BITS   = 8;
  // 100 MHz / 115200 baud
  localparam int UART_DIV_DEFAULT = 868;

  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input logic                      odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// Handshake and serial-line bundle between the UART control block and the TX core.
interface uart_tx_core_if
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) ();

  logic [DIV_W-1:0]          i_clk_div;
  logic [UART_DATA_BITS-1:0] i_tx_data;
  logic                      i_tx_start;
  logic                      o_tx_start_clear;
  logic                      o_tx_busy;
  logic                      o_tx_done;
  logic                      o_txd;

  modport master (
    output i_clk_div, i_tx_data, i_tx_start,
    input  o_tx_start_clear, o_tx_busy, o_tx_done, o_txd
  );

  modport slave (
    input  i_clk_div, i_tx_data, i_tx_start,
    output o_tx_start_clear, o_tx_busy, o_tx_done, o_txd
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Loadable bit-time down-counter; bit_tick marks the last clock of each bit period.
// A divisor of 0 is clamped to 1 when loaded.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic             en,
  output logic             bit_tick
);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] div_eff;

  assign div_eff  = (div == '0) ? DIV_W'(1) : div;
  assign bit_tick = en && (cnt_reg == '0);

  // Divisor is captured on load so later changes to div cannot disturb a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      div_reg <= div_eff;
      cnt_reg <= div_eff - DIV_W'(1);
    end else if (bit_tick) begin
      cnt_reg <= div_reg - DIV_W'(1);
    end else if (en) begin
      cnt_reg <= cnt_reg - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// All outputs are registered; a frame is accepted on a level start and acknowledged by a clear pulse.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_core_if.slave  tx
);

  localparam logic       LAST_STOP = (STOP_BITS == 2);
  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_state_e               state_reg, state_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic [2:0]                bit_cnt_reg, bit_cnt_next;
  logic                      stop_cnt_reg, stop_cnt_next;
  logic                      parity_reg, parity_next;
  logic                      txd_reg, txd_next;
  logic                      busy_reg, busy_next;
  logic                      clear_reg, clear_next;
  logic                      done_reg, done_next;
  logic                      accept;
  logic                      bit_tick;

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .div      (tx.i_clk_div),
    .en       (state_reg != ST_IDLE),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    parity_next   = parity_reg;
    txd_next      = txd_reg;
    busy_next     = busy_reg;
    clear_next    = 1'b0;
    done_next     = 1'b0;
    accept        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        txd_next  = 1'b1;
        busy_next = 1'b0;
        if (tx.i_tx_start) begin
          accept        = 1'b1;
          shift_next    = tx.i_tx_data;
          parity_next   = uart_parity(tx.i_tx_data, PARITY_ODD != 0);
          bit_cnt_next  = '0;
          stop_cnt_next = 1'b0;
          txd_next      = 1'b0;
          busy_next     = 1'b1;
          clear_next    = 1'b1;
          state_next    = ST_START;
        end
      end

      ST_START: begin
        if (bit_tick) begin
          txd_next   = shift_reg[0];
          state_next = ST_DATA;
        end
      end

      // The line is loaded one bit ahead so it changes on the same edge as the state.
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_cnt_reg == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              txd_next   = parity_reg;
              state_next = ST_PARITY;
            end else begin
              txd_next   = 1'b1;
              state_next = ST_STOP;
            end
          end else begin
            txd_next     = shift_reg[1];
            shift_next   = {1'b0, shift_reg[UART_DATA_BITS-1:1]};
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
      end

      ST_PARITY: begin
        if (bit_tick) begin
          txd_next   = 1'b1;
          state_next = ST_STOP;
        end
      end

      ST_STOP: begin
        if (bit_tick) begin
          if (stop_cnt_reg == LAST_STOP) begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end

      default: begin
        txd_next   = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      parity_reg   <= 1'b0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
      clear_reg    <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      parity_reg   <= parity_next;
      txd_reg      <= txd_next;
      busy_reg     <= busy_next;
      clear_reg    <= clear_next;
      done_reg     <= done_next;
    end
  end

  assign tx.o_txd            = txd_reg;
  assign tx.o_tx_busy        = busy_reg;
  assign tx.o_tx_start_clear = clear_reg;
  assign tx.o_tx_done        = done_reg;

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: one plain 8N1 instance and one 8E2 instance,
// each frame checked cycle by cycle against a model of the expected line waveform.
module tb_uart_tx_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_tx_core_if #(.DIV_W(16)) bus0 ();
  uart_tx_core_if #(.DIV_W(16)) bus1 ();

  uart_tx_core #(
    .PARITY_EN (0), .PARITY_ODD (0), .STOP_BITS (1), .DIV_W (16)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .tx (bus0)
  );

  uart_tx_core #(
    .PARITY_EN (1), .PARITY_ODD (0), .STOP_BITS (2), .DIV_W (16)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .tx (bus1)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         b2b;
  } frame_t;

  frame_t q0[$];
  frame_t q1[$];

  int     n_checks = 0;
  int     n_pass   = 0;

  bit     m_active[2];
  int     m_k[2];
  int     m_cyc[2];
  int     m_last_done[2];
  int     m_clears[2];
  frame_t m_cur[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Instance 0 is 8N1 (10 bits), instance 1 is 8E2 (12 bits).
  function automatic int frame_bits(input int id);
    return (id == 0) ? 10 : 12;
  endfunction

  function automatic logic exp_bit(input int id, input frame_t f, input int b);
    logic [7:0] d;
    d = f.data;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (id == 1 && b == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic mon_step(input int id, input logic txd, input logic busy,
                          input logic clr, input logic done);
    int n;
    int b;
    logic eb;
    bit empty;
    m_cyc[id]++;
    if (!m_active[id]) begin
      if (clr) begin
        empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
          check($sformatf("u%0d.unexpected_clear", id), 32'(clr), 32'(0));
        end else begin
          if (id == 0) m_cur[id] = q0.pop_front();
          else         m_cur[id] = q1.pop_front();
          m_active[id] = 1'b1;
          m_k[id]      = 0;
          m_clears[id]++;
          if (m_cur[id].b2b)
            check($sformatf("u%0d.b2b_gap", id), 32'(m_cyc[id] - m_last_done[id]), 32'(1));
        end
      end else begin
        check($sformatf("u%0d.idle_txd", id), 32'(txd), 32'(1));
        check($sformatf("u%0d.idle_busy", id), 32'(busy), 32'(0));
        check($sformatf("u%0d.idle_done", id), 32'(done), 32'(0));
      end
    end
    if (m_active[id]) begin
      m_k[id]++;
      n = frame_bits(id) * m_cur[id].div;
      if (m_k[id] <= n) begin
        b  = (m_k[id] - 1) / m_cur[id].div;
        eb = exp_bit(id, m_cur[id], b);
        check($sformatf("u%0d.d%02h.k%0d.txd", id, m_cur[id].data, m_k[id]), 32'(txd), 32'(eb));
        check($sformatf("u%0d.k%0d.busy", id, m_k[id]), 32'(busy), 32'(1));
        check($sformatf("u%0d.k%0d.clear", id, m_k[id]), 32'(clr), 32'(m_k[id] == 1));
        check($sformatf("u%0d.k%0d.done", id, m_k[id]), 32'(done), 32'(0));
      end else begin
        check($sformatf("u%0d.end.done", id), 32'(done), 32'(1));
        check($sformatf("u%0d.end.busy", id), 32'(busy), 32'(0));
        check($sformatf("u%0d.end.txd", id), 32'(txd), 32'(1));
        check($sformatf("u%0d.end.clear", id), 32'(clr), 32'(0));
        $display("frame u%0d data=0x%02h div=%0d len=%0d complete", id, m_cur[id].data,
                 m_cur[id].div, n);
        m_active[id]    = 1'b0;
        m_last_done[id] = m_cyc[id];
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_step(0, bus0.o_txd, bus0.o_tx_busy, bus0.o_tx_start_clear, bus0.o_tx_done);
      mon_step(1, bus1.o_txd, bus1.o_tx_busy, bus1.o_tx_start_clear, bus1.o_tx_done);
    end
  end

  task automatic drive(input int id, input logic start, input logic [7:0] data,
                       input logic [15:0] div);
    if (id == 0) begin
      bus0.i_tx_start = start; bus0.i_tx_data = data; bus0.i_clk_div = div;
    end else begin
      bus1.i_tx_start = start; bus1.i_tx_data = data; bus1.i_clk_div = div;
    end
  endtask

  task automatic set_start(input int id, input logic v);
    if (id == 0) bus0.i_tx_start = v;
    else         bus1.i_tx_start = v;
  endtask

  function automatic logic clr_of(input int id);
    return (id == 0) ? bus0.o_tx_start_clear : bus1.o_tx_start_clear;
  endfunction

  task automatic start_frame(input int id, input logic [7:0] data, input logic [15:0] div,
                             input bit b2b, input bit keep);
    frame_t f;
    bit seen;
    f.data = data;
    f.div  = (div == 16'd0) ? 1 : int'(div);
    f.b2b  = b2b;
    if (id == 0) q0.push_back(f);
    else         q1.push_back(f);
    drive(id, 1'b1, data, div);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = clr_of(id);
    end
    check($sformatf("u%0d.clear_seen", id), 32'(seen), 32'(1));
    if (!keep) set_start(id, 1'b0);
  endtask

  task automatic wait_idle(input int id);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = !m_active[id] && ((id == 0) ? (q0.size() == 0) : (q1.size() == 0));
    end
    check($sformatf("u%0d.frame_finished", id), 32'(ok), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    drive(0, 1'b0, 8'h00, 16'd4);
    drive(1, 1'b0, 8'h00, 16'd4);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.u0.txd",   32'(bus0.o_txd), 32'(1));
    check("rst.u0.busy",  32'(bus0.o_tx_busy), 32'(0));
    check("rst.u0.clear", 32'(bus0.o_tx_start_clear), 32'(0));
    check("rst.u0.done",  32'(bus0.o_tx_done), 32'(0));
    check("rst.u1.txd",   32'(bus1.o_txd), 32'(1));
    check("rst.u1.busy",  32'(bus1.o_tx_busy), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 8N1 frame
    start_frame(0, 8'hA5, 16'd4, 1'b0, 1'b0);
    wait_idle(0);

    // Even parity with two stop bits
    start_frame(1, 8'h07, 16'd2, 1'b0, 1'b0);
    wait_idle(1);
    start_frame(1, 8'h03, 16'd2, 1'b0, 1'b0);
    wait_idle(1);

    // Back-to-back with start held high across both frames
    c0 = m_clears[0];
    start_frame(0, 8'h55, 16'd1, 1'b0, 1'b1);
    start_frame(0, 8'hAA, 16'd1, 1'b1, 1'b0);
    wait_idle(0);
    check("b2b.clear_count", 32'(m_clears[0] - c0), 32'(2));

    // Inputs disturbed mid-frame, including a stray start pulse
    start_frame(0, 8'h3C, 16'd3, 1'b0, 1'b0);
    repeat (11) @(negedge clk);
    drive(0, 1'b1, 8'hFF, 16'd7);
    @(negedge clk);
    set_start(0, 1'b0);
    wait_idle(0);
    repeat (8) @(negedge clk);

    // Asynchronous reset during data bit 3
    start_frame(0, 8'h96, 16'd4, 1'b0, 1'b0);
    repeat (16) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.txd",   32'(bus0.o_txd), 32'(1));
    check("midrst.busy",  32'(bus0.o_tx_busy), 32'(0));
    check("midrst.done",  32'(bus0.o_tx_done), 32'(0));
    check("midrst.clear", 32'(bus0.o_tx_start_clear), 32'(0));
    m_active[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("postrst.busy", 32'(bus0.o_tx_busy), 32'(0));
    start_frame(0, 8'hC3, 16'd4, 1'b0, 1'b0);
    wait_idle(0);

    // Divisor 0 behaves as 1
    start_frame(0, 8'hFF, 16'd0, 1'b0, 1'b0);
    wait_idle(0);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Serial transmitter for the user-project UART. Accepts a byte from the UART register/control block over a level `start` / pulse `start_clear` handshake. Serializes it on `o_txd` as an asynchronous frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits, at a programmable clocks-per-bit rate. Reports `busy` back so the control block can gate new TX_DATA writes.

## Interface
- `PARITY_EN`, 0: 1 inserts a parity bit after D7.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2.
- `DIV_W`, 16: width of the clocks-per-bit divisor.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_clk_div`  in  DIV_W  clocks per bit; sampled at frame acceptance; 0 is treated as 1.
- `i_tx_data`  in  8  byte to send; sampled at frame acceptance.
- `i_tx_start`  in  1  level request; held high by the control block until `o_tx_start_clear`.
- `o_tx_start_clear`  out  1  one-cycle pulse acknowledging acceptance.
- `o_tx_busy`  out  1  high from acceptance until the frame completes.
- `o_tx_done`  out  1  one-cycle pulse at frame completion.
- `o_txd`  out  1  serial line; idles high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `o_txd`=1, `o_tx_busy`=0. When `i_tx_start`=1 at a clk edge:
  - latch `i_tx_data` into the shift register;
  - latch max(`i_clk_div`,1) into the divisor;
  - compute parity = ^data XOR `PARITY_ODD`;
  - pulse `o_tx_start_clear`, set `o_tx_busy`, go to START.
- START: `o_txd`=0 for one bit time, then DATA.
- DATA: `o_txd` = shift[0] for one bit time per bit, shift right, bit counter 0..7. After bit 7, go to PARITY if `PARITY_EN`, else STOP.
- PARITY: `o_txd` = latched parity for one bit time, then STOP.
- STOP: `o_txd`=1 for `STOP_BITS` bit times. After the last stop bit: pulse `o_tx_done`, clear `o_tx_busy`, go to IDLE.
- Bit time: baud counter counts 0..div-1 and wraps; the state advances on the wrap.
- `o_txd`, `o_tx_busy`, `o_tx_start_clear` and `o_tx_done` are registered outputs.
- `i_tx_start` outside IDLE is ignored; no request is lost because the control block holds start until clear.
- Changes to `i_clk_div` or `i_tx_data` mid-frame have no effect on the current frame.

## Timing
- Reset values: `o_txd`=1, `o_tx_busy`=0, `o_tx_start_clear`=0, `o_tx_done`=0, state IDLE, all counters 0.
- Acceptance edge E (IDLE, start=1). From cycle E+1:
  - `o_tx_start_clear`=1 for exactly one cycle;
  - `o_tx_busy`=1;
  - `o_txd`=0 (start bit).
- Frame length N = (1+8+PARITY_EN+STOP_BITS)·div cycles. `o_txd` holds each bit for exactly div cycles, covering E+1 .. E+N.
- At E+N+1: `o_tx_done`=1 for one cycle, `o_tx_busy`=0, state IDLE, `o_txd`=1.
- Back-to-back: if start is high at E+N+1, the next frame is accepted on that edge. Its start bit begins at E+N+2, giving a minimum inter-frame gap of 1 extra idle-high cycle beyond the stop bit(s).
- div=1: one cycle per bit; same handshake.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). The line goes high with no partial stop bit, and no `o_tx_done` is issued.

## Structure
- Shared package `uart_pkg`:
  - state encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4;
  - `UART_DATA_BITS`=8;
  - default divisor constant `UART_DIV_DEFAULT`;
  - this package is shared with the RX side.
- One sub-module, `uart_baud_gen`:
  - loadable DIV_W-bit down-counter;
  - clear on acceptance;
  - emits `bit_tick` on wrap;
  - the RX side reuses it.

## Test plan
- Basic frame, div=4, data=0xA5, no parity, 1 stop:
  - `o_txd` sequence, each bit 4 cycles: 0,1,0,1,0,0,1,0,1,1;
  - `o_tx_start_clear` pulse at E+1;
  - `o_tx_done` at E+41;
  - `o_tx_busy` high during E+1..E+40.
- Parity and stop bits:
  - PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, div=2, data=0x07 → parity bit=1, frame 24 cycles;
  - data=0x03 → parity bit=0.
- Back-to-back: start held high with 0x55 then 0xAA at div=1 → second start bit begins exactly 2 cycles after the first frame's final stop-bit cycle; exactly 2 clear pulses.
- Mid-frame disturbance:
  - change `i_tx_data` and `i_clk_div` during DATA → current frame unchanged;
  - `i_tx_start` pulsed while busy → no extra clear or frame.
- Reset mid-frame: assert rst_n low during DATA bit 3 → `o_txd`=1 and `o_tx_busy`=0 asynchronously; after release, idle until the next start.
- Divisor 0: `i_clk_div`=0, data=0xFF → behaves as div=1; 10-cycle frame.
